// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with fractional-rate bit timing.
//
// A phase accumulator adds uartRate every clk and ticks when it crosses
// clockRate, so any clockRate/uartRate ratio (>= 4) is handled without
// drift across a frame. The accumulator is preloaded with clockRate/2 on the
// start edge so every tick lands at a bit centre.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   uart       in   asynchronous serial line, idle high
//   available  out  one-cycle strobe, data holds a freshly received byte
//   data       out  last correctly framed byte
`timescale 1ns/1ps
module uart_rx #(
    parameter int clockRate = 76_800_000,
    parameter int uartRate  = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart,
    output logic       available,
    output logic [7:0] data
);

    // Wide enough for acc + uartRate < 2*clockRate.
    localparam int              AW     = $clog2(2 * longint'(clockRate) + 1);
    localparam logic [AW-1:0]   CLK_W  = AW'(clockRate);
    localparam logic [AW-1:0]   RATE_W = AW'(uartRate);
    localparam logic [AW-1:0]   HALF_W = AW'(clockRate / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic          sync1_q, sync2_q;
    logic [1:0]    warm_q;
    logic          armed_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] acc_sum;
    logic          tick;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          available_q;
    logic [7:0]    data_q;
    logic          line;

    assign line      = sync2_q;
    assign available = available_q;
    assign data      = data_q;

    always_comb begin
        acc_sum = acc_q + RATE_W;
        tick    = 1'b0;
        acc_d   = acc_sum;
        if (acc_sum >= CLK_W) begin
            tick  = 1'b1;
            acc_d = acc_sum - CLK_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            warm_q      <= 2'b00;
            armed_q     <= 1'b0;
            acc_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            available_q <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            sync1_q     <= uart;
            sync2_q     <= sync1_q;
            // warm_q[1] marks the point where the synchronizer holds real
            // line samples rather than its reset value; until then a low line
            // must not look like a start edge.
            warm_q      <= {warm_q[0], 1'b1};
            available_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // armed_q means "line seen high", so a start needs a
                    // genuine high-to-low transition (also after framing
                    // errors and reset).
                    if (armed_q && !line) begin
                        state_q <= START;
                        acc_q   <= HALF_W;
                        armed_q <= 1'b0;
                    end else if (warm_q[1] && line) begin
                        armed_q <= 1'b1;
                    end
                end
                START: begin
                    acc_q <= acc_d;
                    if (tick) begin
                        if (line) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    acc_q <= acc_d;
                    if (tick) begin
                        shift_q[idx_q] <= line;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    acc_q <= acc_d;
                    if (tick) begin
                        // Leave at mid stop bit so a back-to-back start edge
                        // is still caught.
                        state_q <= IDLE;
                        if (line) begin
                            data_q      <= shift_q;
                            available_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    // 10 ns clk, 64 ns bit: 6.4 clk per bit, same ratio as the defaults.
    localparam realtime BIT = 64.0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart = 1'b1;
    logic       available;
    logic [7:0] data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .uart      (uart),
        .available (available),
        .data      (data)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one frame; stop_hi=0 makes a framing error.
    task automatic send(input logic [7:0] b, input logic stop_hi, input logic expect_it);
        if (expect_it) exp_q.push_back(b);
        uart = 1'b0;
        #(BIT);
        for (int i = 0; i < 8; i++) begin
            uart = b[i];
            #(BIT);
        end
        uart = stop_hi;
        #(BIT);
        uart = 1'b1;
    endtask

    task automatic monitor();
        logic [7:0] last;
        logic       prev_av;
        logic [7:0] e;
        last    = 8'h00;
        prev_av = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last    = 8'h00;
                prev_av = 1'b0;
            end else begin
                if (available) begin
                    n_checks++;
                    if (prev_av) begin
                        n_fail++;
                        $display("FAIL pulse_width: available high 2 cycles, expected 1");
                    end else if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_pulse: got data %h expected no pulse", data);
                    end else begin
                        e = exp_q.pop_front();
                        if (data !== e) begin
                            n_fail++;
                            $display("FAIL rx_byte: got %h expected %h", data, e);
                        end
                    end
                    last = data;
                end else if (data !== last) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL data_hold: got %h expected %h", data, last);
                    last = data;
                end
                prev_av = available;
            end
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d pulses missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        uart = 1'b1;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check8("reset_available", {7'd0, available}, 8'h00);
        check8("reset_data", data, 8'h00);
        rst = 1'b0;
        #(3.0 * BIT + 3.0);

        // Single ideal frame
        send(8'hA5, 1'b1, 1'b1);
        #(2.0 * BIT);
        drain("a5");

        // Back-to-back, zero idle
        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        #(2.0 * BIT);
        drain("b2b");

        // Quarter-bit glitch, then valid frame
        uart = 1'b0;
        #(BIT / 4.0);
        uart = 1'b1;
        #(4.0 * BIT);
        send(8'h3C, 1'b1, 1'b1);
        #(2.0 * BIT);
        drain("glitch");

        // Framing error: stop low, line held low, then high, then 8'h12
        send(8'h55, 1'b0, 1'b0);
        uart = 1'b0;
        #(BIT);
        uart = 1'b1;
        #(2.0 * BIT);
        check8("framing_data_hold", data, 8'h3C);
        send(8'h12, 1'b1, 1'b1);
        #(2.0 * BIT);
        drain("framing");

        // Stream of incrementing bytes with random 0..1 bit idle
        for (int i = 0; i < 300; i++) begin
            send(8'(i), 1'b1, 1'b1);
            #($urandom_range(0, 64) * 1.0);
        end
        #(2.0 * BIT);
        drain("stream");

        // Reset during bit 4 of 8'hF0 (bits 4..7 high, so no edge after reset)
        uart = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            uart = 1'b0;
            #(BIT);
        end
        uart = 1'b1;
        #(BIT / 2.0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check8("midreset_available", {7'd0, available}, 8'h00);
        check8("midreset_data", data, 8'h00);
        rst = 1'b0;
        #(5.0 * BIT);
        send(8'h81, 1'b1, 1'b1);
        #(2.0 * BIT);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
